// File: rtl/ft_sync_fifo_ctrl.sv
// ft_sync_fifo_ctrl
// Controller for the FT2232H synchronous FIFO port, clocked by CLKOUT.
// It buffers host-to-FPGA reads and FPGA-to-host writes and arbitrates
// between them. The pins are a pure decode of the state register.
//
// Ports:
//   clkout_i, rst_n_i     : FT2232H CLKOUT, async active-low reset
//   rxf_n_i, txe_n_i      : chip status (low = data available / room)
//   data_i, data_o        : pad input value, pad drive value (TX head)
//   data_oe_o             : tristate enable for the shared data bus
//   oe_n_o, rd_n_o, wr_n_o: chip strobes
//   rx_data_o/valid/ready : RX stream to the user (first-word fall-through)
//   tx_data_i/valid/ready : TX stream from the user
//   rx_level_o, tx_level_o: buffer occupancy
module ft_sync_fifo_ctrl #(
    parameter int RX_DEPTH  = 16,
    parameter int TX_DEPTH  = 16,
    parameter int BURST_MAX = 64,
    parameter int ARB_MODE  = 2
) (
    input  logic                      clkout_i,
    input  logic                      rst_n_i,
    input  logic                      rxf_n_i,
    input  logic                      txe_n_i,
    input  logic [7:0]                data_i,
    output logic [7:0]                data_o,
    output logic                      data_oe_o,
    output logic                      oe_n_o,
    output logic                      rd_n_o,
    output logic                      wr_n_o,
    output logic [7:0]                rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    input  logic [7:0]                tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic [$clog2(RX_DEPTH):0] rx_level_o,
    output logic [$clog2(TX_DEPTH):0] tx_level_o
);

    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL  = (RAW+1)'(RX_DEPTH);
    localparam logic [RAW:0] RX_ALMST = (RAW+1)'(RX_DEPTH - 1);
    localparam logic [TAW:0] TX_FULL  = (TAW+1)'(TX_DEPTH);
    localparam logic [TAW:0] TX_ONE   = (TAW+1)'(1);
    localparam logic [31:0]  BMAX     = 32'(BURST_MAX);

    typedef enum logic [1:0] {S_IDLE, S_RD_OE, S_READ, S_WRITE} state_e;

    state_e         state_q, state_d;
    logic           rr_tx_q, rr_tx_d;
    logic [31:0]    burst_q, burst_d, burst_inc;
    logic           burst_done, pick_tx;

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [RAW-1:0] rx_wp_q, rx_rp_q;
    logic [TAW-1:0] tx_wp_q, tx_rp_q;
    logic [RAW:0]   rx_level_q;
    logic [TAW:0]   tx_level_q;

    logic rx_space1, rx_space2, tx_has1, tx_has2;
    logic rx_req, tx_req, rx_cap, tx_acc, rx_pop, tx_push;

    assign rx_space1 = rx_level_q < RX_FULL;
    assign rx_space2 = rx_level_q < RX_ALMST;
    assign tx_has1   = tx_level_q != '0;
    assign tx_has2   = tx_level_q > TX_ONE;
    assign rx_req    = !rxf_n_i && rx_space1;
    assign tx_req    = !txe_n_i && tx_has1;
    assign rx_cap    = (state_q == S_READ)  && !rxf_n_i;
    assign tx_acc    = (state_q == S_WRITE) && !txe_n_i;

    assign rx_valid_o = rx_level_q != '0;
    assign tx_ready_o = tx_level_q < TX_FULL;
    assign rx_pop     = rx_valid_o && rx_ready_i;
    assign tx_push    = tx_valid_i && tx_ready_o;
    assign rx_level_o = rx_level_q;
    assign tx_level_o = tx_level_q;
    assign rx_data_o  = rx_mem[rx_rp_q];
    assign data_o     = tx_mem[tx_rp_q];

    // Counter saturates at BURST_MAX so burst_done stays asserted for the
    // rest of an over-long grant and the yield still happens later.
    always_comb begin
        if (BURST_MAX != 0 && burst_q == BMAX) begin
            burst_inc = burst_q;
        end else begin
            burst_inc = burst_q + 32'(rx_cap || tx_acc);
        end
        burst_done = (BURST_MAX != 0) && (burst_inc == BMAX);
    end

    always_comb begin
        state_d = state_q;
        rr_tx_d = rr_tx_q;
        burst_d = burst_q;
        pick_tx = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_req && tx_req) begin
                    if (ARB_MODE == 0)      pick_tx = 1'b0;
                    else if (ARB_MODE == 1) pick_tx = 1'b1;
                    else                    pick_tx = rr_tx_q;
                end else begin
                    pick_tx = tx_req;
                end
                if (rx_req || tx_req) begin
                    rr_tx_d = !pick_tx;
                    burst_d = '0;
                    state_d = pick_tx ? S_WRITE : S_RD_OE;
                end
            end
            S_RD_OE: begin
                burst_d = '0;
                state_d = rx_req ? S_READ : S_IDLE;
            end
            S_READ: begin
                burst_d = burst_inc;
                if (!(!rxf_n_i && rx_space2 && !(burst_done && tx_req))) state_d = S_IDLE;
            end
            S_WRITE: begin
                burst_d = burst_inc;
                if (!(!txe_n_i && tx_has2 && !(burst_done && rx_req))) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oe_n_o    = 1'b1;
        rd_n_o    = 1'b1;
        wr_n_o    = 1'b1;
        data_oe_o = 1'b0;
        case (state_q)
            S_RD_OE: oe_n_o = 1'b0;
            S_READ: begin
                oe_n_o = 1'b0;
                rd_n_o = 1'b0;
            end
            S_WRITE: begin
                wr_n_o    = 1'b0;
                data_oe_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            rr_tx_q    <= 1'b0;
            burst_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_level_q <= '0;
            tx_level_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_tx_q    <= rr_tx_d;
            burst_q    <= burst_d;
            if (rx_cap)  rx_wp_q <= rx_wp_q + RAW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + RAW'(1);
            if (tx_push) tx_wp_q <= tx_wp_q + TAW'(1);
            if (tx_acc)  tx_rp_q <= tx_rp_q + TAW'(1);
            rx_level_q <= rx_level_q + (RAW+1)'(rx_cap) - (RAW+1)'(rx_pop);
            tx_level_q <= tx_level_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_acc);
        end
    end

    always_ff @(posedge clkout_i) begin
        if (rx_cap)  rx_mem[rx_wp_q] <= data_i;
        if (tx_push) tx_mem[tx_wp_q] <= tx_data_i;
    end

endmodule
